// File: rtl/calendar_pkg.sv
// Shared constants for the calendar date-setting sequencer: state codes,
// field indices and the per-field digit blink masks.
package calendar_pkg;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DAY   = 2'd1;
    localparam logic [1:0] ST_MONTH = 2'd2;
    localparam logic [1:0] ST_YEAR  = 2'd3;

    localparam int FLD_DAY  = 0;
    localparam int FLD_MON  = 1;
    localparam int FLD_YEAR = 2;

    localparam logic [5:0] MASK_DAY  = 6'b000011;
    localparam logic [5:0] MASK_MON  = 6'b001100;
    localparam logic [5:0] MASK_YEAR = 6'b110000;

    function automatic logic [2:0] field_inc(input logic [1:0] st);
        logic [2:0] oh;
        oh = '0;
        case (st)
            ST_DAY:   oh[FLD_DAY]  = 1'b1;
            ST_MONTH: oh[FLD_MON]  = 1'b1;
            ST_YEAR:  oh[FLD_YEAR] = 1'b1;
            default:  oh = '0;
        endcase
        return oh;
    endfunction

    function automatic logic [5:0] field_mask(input logic [1:0] st);
        case (st)
            ST_DAY:   return MASK_DAY;
            ST_MONTH: return MASK_MON;
            ST_YEAR:  return MASK_YEAR;
            default:  return 6'b000000;
        endcase
    endfunction

endpackage

// File: rtl/calendar_set_ctrl_if.sv
// Key / carry inputs and calendar-facing outputs of the date-setting sequencer.
interface calendar_set_ctrl_if;

    logic       key_mode_p;
    logic       key_inc_lvl;
    logic       day_carry_in;
    logic [2:0] cnt_inc;
    logic       full_flag;
    logic [1:0] set_mode;
    logic [5:0] blink_mask;

    modport master (
        output key_mode_p, key_inc_lvl, day_carry_in,
        input  cnt_inc, full_flag, set_mode, blink_mask
    );

    modport slave (
        input  key_mode_p, key_inc_lvl, day_carry_in,
        output cnt_inc, full_flag, set_mode, blink_mask
    );

endinterface

// File: rtl/calendar_key_repeat.sv
// Increment-key edge detector with hold-to-repeat; one pulse on the press,
// then one per REPEAT_RATE_MS once the key has been held REPEAT_DELAY_MS.
module calendar_key_repeat #(
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic Clk,
    input  logic Reset,
    input  logic ms_tick,
    input  logic key_lvl,
    input  logic disarm,
    output logic inc_due,
    output logic inc_p
);

    localparam int REP_W = $clog2(REPEAT_DELAY_MS) + 1;

    logic             key_prev_q, key_prev_d;
    logic             dis_q, dis_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             inc_p_q, inc_p_d;
    logic [REP_W-1:0] rep_nxt;
    logic             edge_seen;
    logic             active;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        inc_due   = 1'b0;
        rep_cnt_d = '0;
        rep_nxt   = rep_cnt_q + 1'b1;
        edge_seen = key_lvl & ~key_prev_q;
        active    = key_lvl & ~dis_q & ~disarm;
        // once disarmed, stay quiet until the key is released
        dis_d      = key_lvl & (dis_q | disarm);
        key_prev_d = key_lvl;
        if (active) begin
            if (edge_seen) begin
                inc_due = 1'b1;
            end else if (ms_tick) begin
                if (rep_nxt >= REP_W'(REPEAT_DELAY_MS)) begin
                    inc_due   = 1'b1;
                    rep_cnt_d = REP_W'(REPEAT_DELAY_MS - REPEAT_RATE_MS);
                end else begin
                    rep_cnt_d = rep_nxt;
                end
            end else begin
                rep_cnt_d = rep_cnt_q;
            end
        end
        inc_p_d = inc_due;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            key_prev_q <= 1'b0;
            dis_q      <= 1'b0;
            rep_cnt_q  <= '0;
            inc_p_q    <= 1'b0;
        end else begin
            key_prev_q <= key_prev_d;
            dis_q      <= dis_d;
            rep_cnt_q  <= rep_cnt_d;
            inc_p_q    <= inc_p_d;
        end
    end

    assign inc_p = inc_p_q;

endmodule

// File: rtl/calendar_set_ctrl.sv
// Date-setting sequencer: mode FSM, ms prescaler, idle timeout, midnight carry
// gating and digit blink for the calendar counter block.
module calendar_set_ctrl #(
    parameter int unsigned CLK_HZ          = 50_000_000,
    parameter int unsigned TIMEOUT_MS      = 10_000,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100,
    parameter int unsigned BLINK_HALF_MS   = 250
) (
    input  logic                Clk,
    input  logic                Reset,
    calendar_set_ctrl_if.slave  bus
);

    import calendar_pkg::*;

    localparam int unsigned PRESC = CLK_HZ / 1000;
    localparam int PRESC_W = $clog2(PRESC) + 1;
    localparam int IDLE_W  = $clog2(TIMEOUT_MS) + 1;
    localparam int BL_W    = $clog2(BLINK_HALF_MS) + 1;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [1:0]         state_q, state_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [BL_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic               phase_q, phase_d;
    logic               carry_pend_q, carry_pend_d;
    logic               full_flag_q, full_flag_d;
    logic [5:0]         blink_mask_q, blink_mask_d;

    logic              ms_tick;
    logic              in_set;
    logic              timeout;
    logic              mode_chg;
    logic              carry_any;
    logic              inc_due;
    logic              inc_p;
    logic [IDLE_W-1:0] idle_nxt;
    logic [BL_W-1:0]   blink_nxt;

    assign ms_tick = (presc_q == PRESC_W'(PRESC - 1));
    assign in_set  = (state_q != ST_RUN);

    calendar_key_repeat #(
        .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
        .REPEAT_RATE_MS (REPEAT_RATE_MS)
    ) u_key_repeat (
        .Clk    (Clk),
        .Reset  (Reset),
        .ms_tick(ms_tick),
        .key_lvl(bus.key_inc_lvl),
        .disarm (bus.key_mode_p | timeout | ~in_set),
        .inc_due(inc_due),
        .inc_p  (inc_p)
    );

    always_comb begin
        presc_d  = ms_tick ? '0 : presc_q + 1'b1;
        idle_nxt = idle_q + 1'b1;
        timeout  = in_set & ms_tick & ~bus.key_mode_p & ~bus.key_inc_lvl &
                   (idle_nxt >= IDLE_W'(TIMEOUT_MS));

        state_d = state_q;
        if (bus.key_mode_p) begin
            state_d = state_q + 2'd1;   // SET_YEAR wraps to RUN
        end else if (timeout) begin
            state_d = ST_RUN;
        end
        mode_chg = (state_d != state_q);

        idle_d = idle_q;
        if (bus.key_mode_p || bus.key_inc_lvl || state_d == ST_RUN) begin
            idle_d = '0;
        end else if (ms_tick) begin
            idle_d = idle_nxt;
        end

        // carry waits in carry_pend until RUN and until no inc pulse is going out
        carry_any    = carry_pend_q | bus.day_carry_in;
        full_flag_d  = carry_any & (state_d == ST_RUN) & ~inc_due;
        carry_pend_d = carry_any & ~full_flag_d;

        blink_nxt   = blink_cnt_q + 1'b1;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (mode_chg || state_d == ST_RUN) begin
            blink_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (ms_tick) begin
            if (blink_nxt >= BL_W'(BLINK_HALF_MS)) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_nxt;
            end
        end
        blink_mask_d = (phase_d && !bus.key_inc_lvl) ? field_mask(state_d) : 6'b000000;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            presc_q      <= '0;
            state_q      <= ST_RUN;
            idle_q       <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b0;
            carry_pend_q <= 1'b0;
            full_flag_q  <= 1'b0;
            blink_mask_q <= '0;
        end else begin
            presc_q      <= presc_d;
            state_q      <= state_d;
            idle_q       <= idle_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            carry_pend_q <= carry_pend_d;
            full_flag_q  <= full_flag_d;
            blink_mask_q <= blink_mask_d;
        end
    end

    assign bus.set_mode   = state_q;
    assign bus.cnt_inc    = inc_p ? field_inc(state_q) : 3'b000;
    assign bus.full_flag  = full_flag_q;
    assign bus.blink_mask = blink_mask_q;

endmodule

// File: tb/tb_calendar_set_ctrl.sv
// Self-checking bench for calendar_set_ctrl: directed scenarios plus a random
// phase, all outputs compared every cycle against a millisecond-level model.
module tb_calendar_set_ctrl;

    localparam int CLK_HZ     = 10_000;
    localparam int TIMEOUT_MS = 50;
    localparam int DELAY_MS   = 5;
    localparam int RATE_MS    = 2;
    localparam int HALF_MS    = 3;
    localparam int PRESC      = CLK_HZ / 1000;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    calendar_set_ctrl_if bus ();

    calendar_set_ctrl #(
        .CLK_HZ         (CLK_HZ),
        .TIMEOUT_MS     (TIMEOUT_MS),
        .REPEAT_DELAY_MS(DELAY_MS),
        .REPEAT_RATE_MS (RATE_MS),
        .BLINK_HALF_MS  (HALF_MS)
    ) dut (
        .Clk  (Clk),
        .Reset(Reset),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // reference model state, in milliseconds and plain integers
    int   m_mode, m_idle_ms, m_mode_ms, m_hold_ms, cyc;
    bit   m_armed, m_prev_inc, m_pend;
    logic [2:0] e_cnt;
    logic       e_full;
    logic [1:0] e_mode;
    logic [5:0] e_mask;
    int   dut_pulses;
    bit   saw_month_blink;
    bit   rnd_inc;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] mask_of(input int mode);
        case (mode)
            1:       return 6'b000011;
            2:       return 6'b001100;
            3:       return 6'b110000;
            default: return 6'b000000;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_idle_ms = 0; m_mode_ms = 0; m_hold_ms = 0; cyc = 0;
        m_armed = 1'b1; m_prev_inc = 1'b0; m_pend = 1'b0;
        e_cnt = '0; e_full = 1'b0; e_mode = '0; e_mask = '0;
    endtask

    task automatic model_step(input bit mp, input bit il, input bit dc);
        bit tick, tmo, pulse, emit;
        int nm;
        tick  = (cyc % PRESC) == PRESC - 1;
        tmo   = (m_mode != 0) && !mp && !il && tick && (m_idle_ms + 1 >= TIMEOUT_MS);
        nm    = mp ? (m_mode + 1) % 4 : (tmo ? 0 : m_mode);
        pulse = 1'b0;
        if (!il) begin
            m_armed   = 1'b1;
            m_hold_ms = 0;
        end else if (mp || m_mode == 0) begin
            m_armed = 1'b0;
        end else if (m_armed) begin
            if (!m_prev_inc) begin
                pulse     = 1'b1;
                m_hold_ms = 0;
            end else if (tick) begin
                m_hold_ms++;
                if (m_hold_ms == DELAY_MS ||
                    (m_hold_ms > DELAY_MS && (m_hold_ms - DELAY_MS) % RATE_MS == 0))
                    pulse = 1'b1;
            end
        end
        e_cnt  = pulse ? 3'(1 << (m_mode - 1)) : 3'b000;
        emit   = (m_pend || dc) && nm == 0 && !pulse;
        m_pend = (m_pend || dc) && !emit;
        e_full = emit;
        if (mp || il || nm == 0) m_idle_ms = 0;
        else if (tick)           m_idle_ms++;
        if (nm != m_mode || nm == 0) m_mode_ms = 0;
        else if (tick)               m_mode_ms++;
        e_mask = (nm != 0 && (m_mode_ms / HALF_MS) % 2 == 1 && !il) ? mask_of(nm) : 6'b000000;
        e_mode = 2'(nm);
        m_mode = nm;
        m_prev_inc = il;
        cyc++;
    endtask

    task automatic step(input bit mp, input bit il, input bit dc);
        bus.key_mode_p   = mp;
        bus.key_inc_lvl  = il;
        bus.day_carry_in = dc;
        @(posedge Clk);
        model_step(mp, il, dc);
        @(negedge Clk);
        check("set_mode",   8'(bus.set_mode),   8'(e_mode));
        check("cnt_inc",    8'(bus.cnt_inc),    8'(e_cnt));
        check("full_flag",  8'(bus.full_flag),  8'(e_full));
        check("blink_mask", 8'(bus.blink_mask), 8'(e_mask));
        check("carry_inc_exclusive", 8'(bus.full_flag & (|bus.cnt_inc)), 8'd0);
        if (|bus.cnt_inc) dut_pulses++;
        if (bus.blink_mask == 6'b001100) saw_month_blink = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        bus.key_mode_p = 1'b0; bus.key_inc_lvl = 1'b0; bus.day_carry_in = 1'b0;
        model_reset();
        #1;
        check("rst_set_mode",   8'(bus.set_mode),   8'd0);
        check("rst_cnt_inc",    8'(bus.cnt_inc),    8'd0);
        check("rst_full_flag",  8'(bus.full_flag),  8'd0);
        check("rst_blink_mask", 8'(bus.blink_mask), 8'd0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        bus.key_mode_p = 1'b0; bus.key_inc_lvl = 1'b0; bus.day_carry_in = 1'b0;
        #3;
        do_reset();

        // midnight carry in RUN: one cycle late, one cycle wide
        idle(3);
        step(1'b0, 1'b0, 1'b1);
        check("run_carry_delay", 8'(bus.full_flag), 8'd1);
        step(1'b0, 1'b0, 1'b0);
        check("run_carry_width", 8'(bus.full_flag), 8'd0);

        // walk the fields, one inc tap in each
        for (int f = 0; f < 3; f++) begin
            step(1'b1, 1'b0, 1'b0);
            check("mode_adv", 8'(bus.set_mode), 8'(f + 1));
            idle(2);
            step(1'b0, 1'b1, 1'b0);
            check("tap_inc", 8'(bus.cnt_inc), 8'(1 << f));
            step(1'b0, 1'b0, 1'b0);
            check("tap_once", 8'(bus.cnt_inc), 8'd0);
            idle(3);
        end
        step(1'b1, 1'b0, 1'b0);
        check("mode_wrap", 8'(bus.set_mode), 8'd0);

        // SET_DAY, hold inc 12 ms
        step(1'b1, 1'b0, 1'b0);
        dut_pulses = 0;
        repeat (120) step(1'b0, 1'b1, 1'b0);
        idle(3);
        check("repeat_count", 8'(dut_pulses), 8'd5);

        // mode key and inc edge together: no pulse, repeat stays disarmed
        dut_pulses = 0;
        step(1'b1, 1'b1, 1'b0);
        repeat (80) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("disarm_no_pulse", 8'(dut_pulses), 8'd0);
        check("disarm_mode", 8'(bus.set_mode), 8'd2);

        // carry held back in SET_YEAR, released on return to RUN
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        idle(5);
        check("set_carry_held", 8'(bus.full_flag), 8'd0);
        step(1'b1, 1'b0, 1'b0);
        check("carry_first_run", 8'(bus.full_flag), 8'd1);
        step(1'b0, 1'b0, 1'b0);
        check("carry_once", 8'(bus.full_flag), 8'd0);

        // year inc and carry due together: cnt_inc first, full_flag next cycle
        repeat (3) step(1'b1, 1'b0, 1'b0);
        idle(2);
        step(1'b0, 1'b1, 1'b1);
        check("aligned_inc", 8'(bus.cnt_inc), 8'h04);
        check("aligned_no_full", 8'(bus.full_flag), 8'd0);
        step(1'b1, 1'b1, 1'b0);
        check("aligned_full", 8'(bus.full_flag), 8'd1);
        check("aligned_run", 8'(bus.set_mode), 8'd0);
        step(1'b0, 1'b0, 1'b0);

        // SET_MONTH blink, inc forces blank, then idle timeout back to RUN
        saw_month_blink = 1'b0;
        repeat (2) step(1'b1, 1'b0, 1'b0);
        idle(40);
        repeat (20) step(1'b0, 1'b1, 1'b0);
        check("mask_forced_off", 8'(bus.blink_mask), 8'd0);
        idle(600);
        check("timeout_run", 8'(bus.set_mode), 8'd0);
        check("blink_seen", 8'(saw_month_blink), 8'd1);
        check("run_mask_off", 8'(bus.blink_mask), 8'd0);

        // random traffic against the model
        rnd_inc = 1'b0;
        repeat (800) begin
            if ($urandom_range(14) == 0) rnd_inc = ~rnd_inc;
            step($urandom_range(39) == 0, rnd_inc, $urandom_range(29) == 0);
        end
        idle(2);

        // reset mid SET_MONTH with a carry pending
        for (int i = 0; i < 4; i++)
            if (m_mode != 2) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("pre_rst_mode", 8'(bus.set_mode), 8'd2);
        #2;
        do_reset();
        idle(30);
        check("post_rst_mode", 8'(bus.set_mode), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
